wb4_fifo_wr_arbiter: RTL

Round-robin arbiter that shares the single Wishbone B4 (pipelined) write port of a sync FIFO between P_NUM_REQ requesters. Sits directly in front of the FIFO's write slave interface. Grants one requester per cycle-bus tenure, bounds each tenure to P_MAX_BURST accepted strobes, and routes the FIFO's acks back to the granted requester. Drains outstanding acks before re-arbitrating.

---
 rtl/wb4_fifo_wr_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/wb4_fifo_wr_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone B4 FIFO write port between
// P_NUM_REQ requesters; bounded bursts, ack routing, drain before re-arbitration.
module wb4_fifo_wr_arbiter #(
    parameter int P_DATA_MSB  = 7,
    parameter int P_NUM_REQ   = 4,
    parameter int P_MAX_BURST = 16
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic [P_NUM_REQ-1:0]                 i_wb4_req_scyc,
    input  logic [P_NUM_REQ-1:0]                 i_wb4_req_sstb,
    input  logic [P_NUM_REQ*(P_DATA_MSB+1)-1:0]  i_wb4_req_sdata,
    output logic [P_NUM_REQ-1:0]                 o_wb4_req_sack,
    output logic [P_NUM_REQ-1:0]                 o_wb4_req_sstall,
    output logic                                 o_wb4_fifo_mcyc,
    output logic                                 o_wb4_fifo_mstb,
    output logic [P_DATA_MSB:0]                  o_wb4_fifo_mdata,
    input  logic                                 i_wb4_fifo_mack,
    input  logic                                 i_wb4_fifo_mstall,
    output logic [P_NUM_REQ-1:0]                 o_grant,
    output logic                                 o_busy
);
    localparam int DW   = P_DATA_MSB + 1;
    localparam int GW   = $clog2(P_NUM_REQ);
    localparam int BC_W = $clog2(P_MAX_BURST + 1);
    localparam int OC_W = BC_W + 1;
    localparam logic [BC_W-1:0] BC_LAST  = BC_W'(P_MAX_BURST - 1);
    localparam logic [GW-1:0]   IDX_LAST = GW'(P_NUM_REQ - 1);
    localparam logic [GW:0]     NUM_REQ  = (GW+1)'(P_NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_DRAIN
    } state_t;

    state_t            state_reg, state_next;
    logic [GW-1:0]     g_reg, g_next;
    logic [GW-1:0]     r_last_reg, r_last_next;
    logic [BC_W-1:0]   bc_reg, bc_next;
    logic [OC_W-1:0]   oc_reg, oc_next;

    logic [DW-1:0]     sdata_arr [P_NUM_REQ];
    logic              pick_found;
    logic [GW-1:0]     pick_idx;
    logic [GW:0]       cand_sum;
    logic [GW-1:0]     cand;
    logic              g_cyc;
    logic              g_stb;
    logic              granting;
    logic              accept;
    logic              ack_live;

    genvar gi;
    generate
        for (gi = 0; gi < P_NUM_REQ; gi++) begin : g_unpack
            assign sdata_arr[gi] = i_wb4_req_sdata[gi*DW +: DW];
        end
    endgenerate

    // Rotating priority: search starts just after the last requester served.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand_sum   = '0;
        cand       = '0;
        for (int i = 1; i <= P_NUM_REQ; i++) begin
            cand_sum = {1'b0, r_last_reg} + (GW+1)'(i);
            cand     = (cand_sum >= NUM_REQ) ? GW'(cand_sum - NUM_REQ) : cand_sum[GW-1:0];
            if (!pick_found && i_wb4_req_scyc[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign g_cyc    = i_wb4_req_scyc[g_reg];
    assign g_stb    = i_wb4_req_sstb[g_reg];
    assign granting = (state_reg == ST_GRANT);
    assign accept   = granting && g_cyc && g_stb && !i_wb4_fifo_mstall;
    // Acks with nothing outstanding belong to a tenure killed by reset.
    assign ack_live = i_wb4_fifo_mack && (oc_reg != '0);

    always_comb begin
        state_next  = state_reg;
        g_next      = g_reg;
        r_last_next = r_last_reg;
        bc_next     = bc_reg;
        oc_next     = oc_reg;

        if (accept && !ack_live) begin
            oc_next = oc_reg + 1'b1;
        end else if (!accept && ack_live) begin
            oc_next = oc_reg - 1'b1;
        end

        case (state_reg)
            ST_IDLE: begin
                if (pick_found) begin
                    g_next     = pick_idx;
                    bc_next    = '0;
                    state_next = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (accept) begin
                    bc_next = bc_reg + 1'b1;
                end
                if (!g_cyc || (accept && bc_reg == BC_LAST)) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Leave as soon as the final ack lands so the next grant follows 2 cycles later.
                if (oc_next == '0) begin
                    state_next  = ST_IDLE;
                    r_last_next = g_reg;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg  <= ST_IDLE;
            g_reg      <= '0;
            r_last_reg <= IDX_LAST;
            bc_reg     <= '0;
            oc_reg     <= '0;
        end else begin
            state_reg  <= state_next;
            g_reg      <= g_next;
            r_last_reg <= r_last_next;
            bc_reg     <= bc_next;
            oc_reg     <= oc_next;
        end
    end

    assign o_busy           = (state_reg != ST_IDLE);
    assign o_wb4_fifo_mcyc  = o_busy;
    assign o_wb4_fifo_mstb  = granting && g_cyc && g_stb;
    assign o_wb4_fifo_mdata = granting ? sdata_arr[g_reg] : '0;

    generate
        for (gi = 0; gi < P_NUM_REQ; gi++) begin : g_req
            assign o_grant[gi]          = o_busy && (g_reg == GW'(gi));
            assign o_wb4_req_sstall[gi] = !(granting && (g_reg == GW'(gi))) || i_wb4_fifo_mstall;
            assign o_wb4_req_sack[gi]   = o_grant[gi] && ack_live && i_wb4_req_scyc[gi];
        end
    endgenerate

endmodule
